// File: rtl/cpu_boot_loader.sv
// Boot-time program loader: accepts a LEN/data/CSUM byte frame, writes assembled
// instructions into instruction memory and releases the CPU only after a verified image.
module cpu_boot_loader #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   start,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_rst,
    output logic                   done,
    output logic                   err
);
    // state  | meaning
    // S_LEN  | waiting for LEN byte (instruction count)
    // S_DATA | receiving instruction bytes, MSB-first
    // S_CSUM | waiting for checksum byte
    // S_DONE | image verified, CPU released
    // S_ERR  | image rejected, CPU held in reset

    localparam int BYTES = INSTR_WIDTH / 8;
    localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    state_t                 state, state_next;
    logic [7:0]             len_q;
    logic [7:0]             csum_q;
    logic [INSTR_WIDTH-1:0] asm_q;
    logic [INSTR_WIDTH-1:0] asm_next;
    logic [BW-1:0]          byte_idx;
    logic [ADDR_WIDTH:0]    instr_cnt;
    logic                   xfer;
    logic                   last_byte;
    logic                   last_instr;

    assign in_ready   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign done       = (state == S_DONE);
    assign err        = (state == S_ERR);
    assign cpu_rst    = (state != S_DONE);
    assign xfer       = in_valid && in_ready;
    assign asm_next   = (asm_q << 8) | INSTR_WIDTH'(in_data);
    assign last_byte  = (byte_idx == LAST_BYTE);
    assign last_instr = (32'(instr_cnt) + 32'd1) == 32'(len_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_LEN;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LEN: begin
                if (in_valid) begin
                    if (32'(in_data) > DEPTH) state_next = S_ERR;
                    else if (in_data == 8'd0) state_next = S_CSUM;
                    else                      state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (in_valid && last_byte && last_instr) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (in_valid) state_next = (in_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE:  if (start) state_next = S_LEN;
            S_ERR:   if (start) state_next = S_LEN;
            default: state_next = S_LEN;
        endcase
    end

    // The final write of a frame is registered on its last data byte, so it always
    // lands before the CSUM byte can move the FSM to S_DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            csum_q     <= '0;
            asm_q      <= '0;
            byte_idx   <= '0;
            instr_cnt  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (xfer) begin
                case (state)
                    S_LEN: begin
                        len_q     <= in_data;
                        csum_q    <= in_data;
                        instr_cnt <= '0;
                        byte_idx  <= '0;
                    end
                    S_DATA: begin
                        csum_q <= csum_q ^ in_data;
                        asm_q  <= asm_next;
                        if (last_byte) begin
                            byte_idx   <= '0;
                            imem_we    <= 1'b1;
                            imem_addr  <= instr_cnt[ADDR_WIDTH-1:0];
                            imem_wdata <= asm_next;
                            instr_cnt  <= instr_cnt + 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed bench for cpu_boot_loader: frames with hand-computed writes and status.
module tb_cpu_boot_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        start = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  wa[$];
    logic [15:0] wd[$];

    cpu_boot_loader #(.INSTR_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte %h: in_ready=%b, required 1", b, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] f[8], input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(f[i]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({in_ready, imem_we, cpu_rst, done, err} !== 5'b10100) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 10100", {in_ready, imem_we, cpu_rst, done, err});
        end
        vectors++;
        if (imem_addr !== 8'h00 || imem_wdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_bus: addr=%h wdata=%h, required 00/0000", imem_addr, imem_wdata);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [7:0] f[8] = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00, 8'h00};
        wa.delete();
        wd.delete();
        send_frame(f, 6, 1'b0);
        vectors++;
        if (wa.size() != 2) begin
            miscompares++;
            $display("FAIL good_count: %0d writes, required 2", wa.size());
        end else begin
            vectors++;
            if (wa[0] !== 8'd0 || wd[0] !== 16'h1234 || wa[1] !== 8'd1 || wd[1] !== 16'hABCD) begin
                miscompares++;
                $display("FAIL good_writes: [%h]=%h [%h]=%h, required [00]=1234 [01]=abcd",
                         wa[0], wd[0], wa[1], wd[1]);
            end
        end
        vectors++;
        if ({done, err, cpu_rst, in_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL good_status: done/err/cpu_rst/in_ready=%b, required 1000",
                     {done, err, cpu_rst, in_ready});
        end
    endtask

    task automatic test_start_reload();
        logic [7:0] f[8] = '{8'h01, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start();
        vectors++;
        if ({done, err, cpu_rst, in_ready} !== 4'b0011) begin
            miscompares++;
            $display("FAIL start_status: done/err/cpu_rst/in_ready=%b, required 0011",
                     {done, err, cpu_rst, in_ready});
        end
        wa.delete();
        wd.delete();
        send_frame(f, 3, 1'b0);
        vectors++;
        if (wa.size() != 1 || wa[0] !== 8'd0 || wd[0] !== 16'h0007) begin
            miscompares++;
            $display("FAIL reload_write: %0d writes, required one [00]=0007", wa.size());
        end
        vectors++;
        if (done !== 1'b0 || cpu_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_pending: done=%b cpu_rst=%b, required 0/1", done, cpu_rst);
        end
        send_byte(8'h06);
        repeat (2) @(negedge clk);
        vectors++;
        if ({done, err, cpu_rst, in_ready} !== 4'b1000 || wa.size() != 1) begin
            miscompares++;
            $display("FAIL reload_status: flags=%b writes=%0d, required 1000 and 1",
                     {done, err, cpu_rst, in_ready}, wa.size());
        end
    endtask

    task automatic test_write_timing();
        logic [7:0] f[8] = '{8'h01, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start();
        send_byte(f[0]);
        send_byte(f[1]);
        send_byte(f[2]);
        @(negedge clk);
        vectors++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 16'h5AC3) begin
            miscompares++;
            $display("FAIL write_timing: we=%b addr=%h wdata=%h, required 1/00/5ac3",
                     imem_we, imem_addr, imem_wdata);
        end
        @(negedge clk);
        vectors++;
        if (imem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL write_width: we=%b one cycle later, required 0", imem_we);
        end
        send_byte(8'h01 ^ 8'h5A ^ 8'hC3);
        repeat (2) @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL timing_done: done=%b, required 1", done);
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] f[8] = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43, 8'h00, 8'h00};
        pulse_start();
        wa.delete();
        wd.delete();
        send_frame(f, 6, 1'b0);
        vectors++;
        if (wa.size() != 2 || wd[0] !== 16'h1234 || wd[1] !== 16'hABCD) begin
            miscompares++;
            $display("FAIL bad_writes: %0d writes, required [00]=1234 [01]=abcd", wa.size());
        end
        vectors++;
        if ({done, err, cpu_rst, in_ready} !== 4'b0110) begin
            miscompares++;
            $display("FAIL bad_status: done/err/cpu_rst/in_ready=%b, required 0110",
                     {done, err, cpu_rst, in_ready});
        end
        @(negedge clk);
        in_data  = 8'h99;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if ({done, err, cpu_rst, in_ready} !== 4'b0110) begin
            miscompares++;
            $display("FAIL err_sticky: done/err/cpu_rst/in_ready=%b, required 0110",
                     {done, err, cpu_rst, in_ready});
        end
    endtask

    task automatic test_gaps();
        logic [7:0] f[8] = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00, 8'h00};
        pulse_start();
        wa.delete();
        wd.delete();
        send_frame(f, 6, 1'b1);
        vectors++;
        if (wa.size() != 2 || wa[0] !== 8'd0 || wd[0] !== 16'h1234 ||
            wa[1] !== 8'd1 || wd[1] !== 16'hABCD) begin
            miscompares++;
            $display("FAIL gaps_writes: %0d writes, required [00]=1234 [01]=abcd", wa.size());
        end
        vectors++;
        if ({done, err, cpu_rst} !== 3'b100) begin
            miscompares++;
            $display("FAIL gaps_status: done/err/cpu_rst=%b, required 100", {done, err, cpu_rst});
        end
    endtask

    task automatic test_empty();
        logic [7:0] ok[8]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] bad[8] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start();
        wa.delete();
        wd.delete();
        send_frame(ok, 2, 1'b0);
        vectors++;
        if (wa.size() != 0 || {done, err, cpu_rst} !== 3'b100) begin
            miscompares++;
            $display("FAIL empty_ok: writes=%0d done/err/cpu_rst=%b, required 0 and 100",
                     wa.size(), {done, err, cpu_rst});
        end
        pulse_start();
        send_frame(bad, 2, 1'b0);
        vectors++;
        if (wa.size() != 0 || {done, err, cpu_rst} !== 3'b011) begin
            miscompares++;
            $display("FAIL empty_bad: writes=%0d done/err/cpu_rst=%b, required 0 and 011",
                     wa.size(), {done, err, cpu_rst});
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] f[8] = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00, 8'h00};
        pulse_start();
        wa.delete();
        wd.delete();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        vectors++;
        if (imem_we !== 1'b1 || imem_wdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL pre_reset_write: we=%b wdata=%h, required 1/1234", imem_we, imem_wdata);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready, imem_we, cpu_rst, done, err} !== 5'b10100 ||
            imem_addr !== 8'h00 || imem_wdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL async_reset: flags=%b addr=%h wdata=%h, required 10100/00/0000",
                     {in_ready, imem_we, cpu_rst, done, err}, imem_addr, imem_wdata);
        end
        @(negedge clk);
        rst = 1'b1;
        wa.delete();
        wd.delete();
        send_frame(f, 6, 1'b0);
        vectors++;
        if (wa.size() != 2 || wa[0] !== 8'd0 || wd[0] !== 16'h1234 ||
            wa[1] !== 8'd1 || wd[1] !== 16'hABCD) begin
            miscompares++;
            $display("FAIL replay_writes: %0d writes, required [00]=1234 [01]=abcd", wa.size());
        end
        vectors++;
        if ({done, err, cpu_rst} !== 3'b100) begin
            miscompares++;
            $display("FAIL replay_status: done/err/cpu_rst=%b, required 100", {done, err, cpu_rst});
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_start_reload();
        test_write_timing();
        test_bad_csum();
        test_gaps();
        test_empty();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
